// File: rtl/xvc_mm_arbiter_if.sv
// Bundle for the two-requester register arbiter: requester ports, downstream port,
// grant and timeout indication.
interface xvc_mm_arbiter_if;
  // Handshake: a requester holds a non-WAIT opcode (with addr/wdata) until it sees a
  // rvalid/wdone pulse; busy=1 means the port cannot be served this cycle; completion
  // pulses are single-cycle; rdata is only meaningful (and otherwise 0) while rvalid=1.
  logic [11:0] r0_addr,   r1_addr;
  logic [31:0] r0_wdata,  r1_wdata;
  logic [1:0]  r0_opcode, r1_opcode;
  logic [31:0] r0_rdata,  r1_rdata;
  logic        r0_rvalid, r1_rvalid;
  logic        r0_wdone,  r1_wdone;
  logic        r0_busy,   r1_busy;
  logic [11:0] m_addr;
  logic [31:0] m_wdata;
  logic [1:0]  m_opcode;
  logic [31:0] m_rdata;
  logic        m_rvalid;
  logic        m_wdone;
  logic        m_busy;
  logic [1:0]  grant;
  logic        timeout_err;

  modport master (
    input  r0_addr, r1_addr, r0_wdata, r1_wdata, r0_opcode, r1_opcode,
    output r0_rdata, r1_rdata, r0_rvalid, r1_rvalid, r0_wdone, r1_wdone, r0_busy, r1_busy,
    output m_addr, m_wdata, m_opcode,
    input  m_rdata, m_rvalid, m_wdone, m_busy,
    output grant, timeout_err
  );

  modport slave (
    output r0_addr, r1_addr, r0_wdata, r1_wdata, r0_opcode, r1_opcode,
    input  r0_rdata, r1_rdata, r0_rvalid, r1_rvalid, r0_wdone, r1_wdone, r0_busy, r1_busy,
    input  m_addr, m_wdata, m_opcode,
    output m_rdata, m_rvalid, m_wdone, m_busy,
    input  grant, timeout_err
  );
endinterface

// File: rtl/xvc_mm_arbiter.sv
// Round-robin arbiter sharing one downstream register port between two requesters,
// with a per-transaction timeout and a fixed quiet gap after each completion.
module xvc_mm_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned GAP_CYCLES     = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  xvc_mm_arbiter_if.master bus,
  output logic [1:0]       dbg_state
);
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ACTIVE = 2'd1, ST_GAP = 2'd2} state_e;

  localparam logic [1:0]  OP_WAIT  = 2'd0;
  localparam logic [1:0]  OP_WRITE = 2'd1;
  localparam logic [1:0]  OP_READ  = 2'd2;
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);

  state_e      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic        last_q,  last_d;  // index of the requester served most recently
  logic [11:0] addr_q,  addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  op_q,    op_d;
  logic [15:0] cnt_q,   cnt_d;   // timeout count in ACTIVE, gap count in GAP

  logic        req0, req1, pick1, active, done, tmo, fin;
  logic        rsp_rd0, rsp_rd1;
  logic [31:0] rsp_data;

  assign req0   = (bus.r0_opcode == OP_WRITE) || (bus.r0_opcode == OP_READ);
  assign req1   = (bus.r1_opcode == OP_WRITE) || (bus.r1_opcode == OP_READ);
  assign pick1  = req1 && (!req0 || !last_q);
  assign active = (state_q == ST_ACTIVE);
  assign done   = active && (((op_q == OP_WRITE) && bus.m_wdone) ||
                             ((op_q == OP_READ)  && bus.m_rvalid));
  assign tmo    = active && !done && (cnt_q == TMO_LAST);
  // Gating with rst_n keeps a transaction abandoned by reset from emitting a pulse.
  assign fin    = (done || tmo) && rst_n;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req0 || req1) begin
          state_d = ST_ACTIVE;
          grant_d = pick1 ? 2'b10 : 2'b01;
          addr_d  = pick1 ? bus.r1_addr   : bus.r0_addr;
          wdata_d = pick1 ? bus.r1_wdata  : bus.r0_wdata;
          op_d    = pick1 ? bus.r1_opcode : bus.r0_opcode;
          cnt_d   = 16'd0;
        end
      end
      ST_ACTIVE: begin
        if (done || tmo) begin
          state_d = ST_GAP;
          last_d  = grant_q[1];
          cnt_d   = 16'd0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
          grant_d = 2'b00;
          cnt_d   = 16'd0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = 2'b00;
        cnt_d   = 16'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= 2'b00;
      last_q  <= 1'b1;
      addr_q  <= 12'd0;
      wdata_q <= 32'd0;
      op_q    <= OP_WAIT;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  // A timed-out read returns all ones so the requester can tell it from real data.
  assign rsp_data = tmo ? 32'hFFFF_FFFF : bus.m_rdata;
  assign rsp_rd0  = fin && (op_q == OP_READ) && grant_q[0];
  assign rsp_rd1  = fin && (op_q == OP_READ) && grant_q[1];

  assign bus.r0_rvalid = rsp_rd0;
  assign bus.r1_rvalid = rsp_rd1;
  assign bus.r0_rdata  = rsp_rd0 ? rsp_data : 32'd0;
  assign bus.r1_rdata  = rsp_rd1 ? rsp_data : 32'd0;
  assign bus.r0_wdone  = fin && (op_q == OP_WRITE) && grant_q[0];
  assign bus.r1_wdone  = fin && (op_q == OP_WRITE) && grant_q[1];
  assign bus.r0_busy   = (state_q == ST_GAP) || (active && (grant_q[0] ? bus.m_busy : 1'b1));
  assign bus.r1_busy   = (state_q == ST_GAP) || (active && (grant_q[1] ? bus.m_busy : 1'b1));

  assign bus.m_addr      = addr_q;
  assign bus.m_wdata     = wdata_q;
  assign bus.m_opcode    = (active && !bus.m_busy) ? op_q : OP_WAIT;
  assign bus.grant       = grant_q;
  assign bus.timeout_err = tmo && rst_n;
  assign dbg_state       = state_q;
endmodule

// File: tb/tb_xvc_mm_arbiter.sv
// Scoreboarded bench for xvc_mm_arbiter: directed arbitration, busy, timeout, stray
// pulse and mid-transaction reset scenarios plus a short randomised tail.
module tb_xvc_mm_arbiter;
  localparam int TMO  = 16;
  localparam int GAPC = 2;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_READ  = 2'd2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] dbg_state;

  xvc_mm_arbiter_if bus();

  xvc_mm_arbiter #(.TIMEOUT_CYCLES(TMO), .GAP_CYCLES(GAPC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.master),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  // {valid, port, is_read, data}
  logic [34:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic drive_req(input int port, input logic [1:0] op, input logic [11:0] addr,
                           input logic [31:0] wd);
    if (port == 0) begin
      bus.r0_opcode = op; bus.r0_addr = addr; bus.r0_wdata = wd;
    end else begin
      bus.r1_opcode = op; bus.r1_addr = addr; bus.r1_wdata = wd;
    end
  endtask

  function automatic logic own_busy(input int port);
    return (port == 0) ? bus.r0_busy : bus.r1_busy;
  endfunction

  function automatic logic other_busy(input int port);
    return (port == 0) ? bus.r1_busy : bus.r0_busy;
  endfunction

  task automatic push_exp(input int port, input logic [1:0] op, input logic [31:0] rd);
    exp_q.push_back({1'b1, 1'(port), (op == OP_READ), (op == OP_READ) ? rd : 32'd0});
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    drive_req(0, 2'd0, 12'd0, 32'd0);
    drive_req(1, 2'd0, 12'd0, 32'd0);
    bus.m_rdata = 32'd0; bus.m_rvalid = 1'b0; bus.m_wdone = 1'b0; bus.m_busy = 1'b0;
    cyc(); cyc(); settle();
    check("rst_grant",   64'(bus.grant), 64'd0);
    check("rst_opcode",  64'(bus.m_opcode), 64'd0);
    check("rst_addr",    64'(bus.m_addr), 64'd0);
    check("rst_wdata",   64'(bus.m_wdata), 64'd0);
    check("rst_tmo",     64'(bus.timeout_err), 64'd0);
    check("rst_state",   64'(dbg_state), 64'd0);
    cyc(); rst_n = 1'b1; settle();
    check("rel_busy0", 64'(bus.r0_busy), 64'd0);
    check("rel_busy1", 64'(bus.r1_busy), 64'd0);
  endtask

  task automatic wait_grant(input int port);
    int n = 0;
    do begin
      cyc(); settle(); n++;
    end while (bus.grant == 2'b00 && n < 20);
    check("grant", 64'(bus.grant), 64'(1 << port));
    check("state_active", 64'(dbg_state), 64'd1);
  endtask

  task automatic finish_gap(input int port);
    cyc();
    bus.m_wdone = 1'b0; bus.m_rvalid = 1'b0; bus.m_rdata = 32'd0; bus.m_busy = 1'b0;
    settle();
    check("gap_opcode", 64'(bus.m_opcode), 64'd0);
    check("gap_busy0",  64'(bus.r0_busy), 64'd1);
    check("gap_busy1",  64'(bus.r1_busy), 64'd1);
    check("gap_grant",  64'(bus.grant), 64'(1 << port));
    check("gap_tmo",    64'(bus.timeout_err), 64'd0);
    check("gap_state",  64'(dbg_state), 64'd2);
    cyc(); settle();
    check("gap2_opcode", 64'(bus.m_opcode), 64'd0);
    check("gap2_busy0",  64'(bus.r0_busy), 64'd1);
    check("gap2_busy1",  64'(bus.r1_busy), 64'd1);
    cyc(); settle();
    check("idle_grant", 64'(bus.grant), 64'd0);
    check("idle_state", 64'(dbg_state), 64'd0);
    check("idle_busy0", 64'(bus.r0_busy), 64'd0);
    check("idle_busy1", 64'(bus.r1_busy), 64'd0);
  endtask

  // Requester must already be driving; completion lands on ACTIVE cycle hold+1.
  task automatic serve(input int port, input logic [1:0] op, input logic [11:0] addr,
                       input logic [31:0] wd, input logic [31:0] rd, input int hold,
                       input bit with_busy, input bit drop, input bit stray);
    wait_grant(port);
    if (drop) drive_req(port, 2'd0, ~addr, ~wd);
    check("m_addr",  64'(bus.m_addr), 64'(addr));
    check("m_wdata", 64'(bus.m_wdata), 64'(wd));
    for (int c = 1; c <= hold; c++) begin
      if (c > 1) begin
        cyc();
        if (stray && c == hold) begin
          if (op == OP_WRITE) begin
            bus.m_rvalid = 1'b1; bus.m_rdata = $urandom;
          end else begin
            bus.m_wdone = 1'b1;
          end
        end
        settle();
      end
      check("act_opcode",   64'(bus.m_opcode), with_busy ? 64'd0 : 64'(op));
      check("act_own_busy", 64'(own_busy(port)), 64'(with_busy));
      check("act_oth_busy", 64'(other_busy(port)), 64'd1);
      check("act_tmo",      64'(bus.timeout_err), 64'd0);
      check("act_grant",    64'(bus.grant), 64'(1 << port));
    end
    cyc();
    bus.m_busy = 1'b0;
    if (op == OP_WRITE) begin
      bus.m_wdone = 1'b1; bus.m_rvalid = 1'b0; bus.m_rdata = 32'd0;
    end else begin
      bus.m_wdone = 1'b0; bus.m_rvalid = 1'b1; bus.m_rdata = rd;
    end
    push_exp(port, op, rd);
    settle();
    check("cpl_tmo",    64'(bus.timeout_err), 64'd0);
    check("cpl_state",  64'(dbg_state), 64'd1);
    check("cpl_opcode", 64'(bus.m_opcode), 64'(op));
    finish_gap(port);
  endtask

  task automatic timeout_txn(input int port, input logic [1:0] op, input logic [11:0] addr);
    drive_req(port, op, addr, 32'hCAFE_0000);
    wait_grant(port);
    drive_req(port, 2'd0, 12'd0, 32'd0);
    for (int c = 1; c < TMO; c++) begin
      if (c > 1) begin
        cyc(); settle();
      end
      check("pre_tmo", 64'(bus.timeout_err), 64'd0);
    end
    cyc();
    push_exp(port, op, 32'hFFFF_FFFF);
    settle();
    check("tmo_pulse", 64'(bus.timeout_err), 64'd1);
    check("tmo_state", 64'(dbg_state), 64'd1);
    finish_gap(port);
  endtask

  // Response monitor: every completion pulse is matched against the expected queue.
  always @(negedge clk) begin
    logic [34:0] obs;
    logic [34:0] e;
    if (bus.r0_rvalid || bus.r0_wdone) begin
      obs = {1'b1, 1'b0, bus.r0_rvalid, bus.r0_rdata};
      e   = (exp_q.size() != 0) ? exp_q.pop_front() : 35'd0;
      check("resp_r0", 64'(obs), 64'(e));
    end
    if (bus.r1_rvalid || bus.r1_wdone) begin
      obs = {1'b1, 1'b1, bus.r1_rvalid, bus.r1_rdata};
      e   = (exp_q.size() != 0) ? exp_q.pop_front() : 35'd0;
      check("resp_r1", 64'(obs), 64'(e));
    end
    if (bus.m_rvalid && !bus.r0_rvalid) check("r0_rdata_zero", 64'(bus.r0_rdata), 64'd0);
    if (bus.m_rvalid && !bus.r1_rvalid) check("r1_rdata_zero", 64'(bus.r1_rdata), 64'd0);
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish, expected finish before %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    reset_dut();

    // single write, completion three cycles into ACTIVE
    drive_req(0, OP_WRITE, 12'h004, 32'h1234_5678);
    serve(0, OP_WRITE, 12'h004, 32'h1234_5678, 32'd0, 3, 1'b0, 1'b1, 1'b0);

    // simultaneous reads from reset: r0, r1, then r0 again
    reset_dut();
    drive_req(0, OP_READ, 12'h010, 32'd0);
    drive_req(1, OP_READ, 12'h020, 32'd0);
    serve(0, OP_READ, 12'h010, 32'd0, 32'h1111_0001, 1, 1'b0, 1'b0, 1'b0);
    serve(1, OP_READ, 12'h020, 32'd0, 32'h2222_0002, 1, 1'b0, 1'b0, 1'b0);
    serve(0, OP_READ, 12'h010, 32'd0, 32'h3333_0003, 1, 1'b0, 1'b1, 1'b0);
    drive_req(1, 2'd0, 12'd0, 32'd0);

    // downstream busy for five cycles, then read data
    bus.m_busy = 1'b1;
    drive_req(1, OP_READ, 12'h0AB, 32'd0);
    serve(1, OP_READ, 12'h0AB, 32'd0, 32'hA5A5_A5A5, 5, 1'b1, 1'b1, 1'b0);

    // stray read pulse during a write is ignored
    w = $urandom;
    drive_req(0, OP_WRITE, 12'h100, w);
    serve(0, OP_WRITE, 12'h100, w, 32'd0, 3, 1'b0, 1'b1, 1'b1);

    // timeouts for a write and a read
    timeout_txn(0, OP_WRITE, 12'h200);
    timeout_txn(1, OP_READ, 12'h300);

    // completion on the timeout cycle wins
    drive_req(1, OP_WRITE, 12'h3FC, 32'h0BAD_F00D);
    serve(1, OP_WRITE, 12'h3FC, 32'h0BAD_F00D, 32'd0, TMO - 1, 1'b0, 1'b1, 1'b0);

    // randomised single-requester transactions
    for (int i = 0; i < 4; i++) begin
      int          p;
      logic [1:0]  op;
      logic [11:0] a;
      logic [31:0] d, r;
      int          h;
      bit          b;
      p  = $urandom_range(0, 1);
      op = 2'($urandom_range(1, 2));
      a  = 12'($urandom);
      d  = (op == OP_WRITE) ? $urandom : 32'd0;
      r  = $urandom;
      h  = $urandom_range(1, 4);
      b  = 1'($urandom_range(0, 1));
      bus.m_busy = b;
      drive_req(p, op, a, d);
      serve(p, op, a, d, r, h, b, 1'b1, 1'b0);
    end

    // reset while a read is in flight: no response must escape
    drive_req(1, OP_READ, 12'h055, 32'd0);
    wait_grant(1);
    drive_req(1, 2'd0, 12'd0, 32'd0);
    cyc();
    rst_n = 1'b0; bus.m_rvalid = 1'b1; bus.m_rdata = 32'h0000_1234;
    settle();
    cyc(); settle();
    check("mid_rst_opcode", 64'(bus.m_opcode), 64'd0);
    check("mid_rst_grant",  64'(bus.grant), 64'd0);
    check("mid_rst_state",  64'(dbg_state), 64'd0);
    cyc();
    rst_n = 1'b1; bus.m_rvalid = 1'b0; bus.m_rdata = 32'd0;
    settle();
    check("post_rst_busy0", 64'(bus.r0_busy), 64'd0);
    check("post_rst_busy1", 64'(bus.r1_busy), 64'd0);
    cyc(); cyc(); settle();

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
